// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants and types for the CNN front-end pipeline.
//                DATA_W   - default pixel width (Q8.8 from the normalizer)
//                KERNEL_K - convolution kernel edge length
//                pixel_t  - one pixel
//                window_t - packed KxK window, element 3*r+c = row r, col c
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_W   = 16;
    localparam int KERNEL_K = 3;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef pixel_t [KERNEL_K*KERNEL_K-1:0] window_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/conv_window_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One-row pixel delay. Combinational read, registered write,
//                so a read and a write to the same address in one cycle
//                returns the old contents (read-before-write).
//  Ports       : clk     - rising-edge clock
//                en      - write enable (one accepted pixel)
//                addr    - column address
//                wr_data - pixel written at addr
//                rd_data - pixel stored at addr before this cycle's write
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    // Storage is deliberately not reset; every location is rewritten
    // before the window logic can consume it.
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[addr] <= wr_data;
        end
    end

endmodule : line_buffer
`default_nettype wire

// File: rtl/conv_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_3x3
//  Description : 3x3 sliding-window generator for a raster pixel stream.
//                Two chained line buffers supply the rows above the current
//                pixel; a 3x3 register window shifts left on every accepted
//                pixel. Windows lying fully inside the frame are presented
//                one cycle after their bottom-right pixel is accepted.
//  Ports       : clk, rst             - clock, sync active-high reset
//                valid_in, pixel_in   - pixel stream, no backpressure
//                sof_in               - marks pixel as (0,0) of a new frame
//                valid_out            - window/position outputs valid
//                window_out           - packed window, slice 3*r+c
//                win_row, win_col     - window top-left coordinate
//                frame_done           - pulse with the last window of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_3x3 #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int DATA_W     = cnn_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [DATA_W-1:0]             pixel_in,
    input  logic                          sof_in,
    output logic                          valid_out,
    output logic [9*DATA_W-1:0]           window_out,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          frame_done
);

    import cnn_pkg::*;

    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int WIN = KERNEL_K * KERNEL_K;

    // A window is complete once the pixel position reaches KERNEL_K-1 in
    // both dimensions; the same value is the top-left offset.
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]               r_col_cnt;
    logic [RW-1:0]               r_row_cnt;
    logic [WIN-1:0][DATA_W-1:0]  r_window;
    logic                        r_valid_out;
    logic [RW-1:0]               r_win_row;
    logic [CW-1:0]               r_win_col;
    logic                        r_frame_done;

    logic [CW-1:0]               w_c;
    logic [RW-1:0]               w_r;
    logic                        w_accept;
    logic                        w_emit;
    logic [DATA_W-1:0]           w_mid;
    logic [DATA_W-1:0]           w_top;

    // sof_in overrides the running counters so a new frame can start at
    // any point, including mid-frame.
    assign w_c      = sof_in ? '0 : r_col_cnt;
    assign w_r      = sof_in ? '0 : r_row_cnt;
    assign w_accept = valid_in & ~rst;
    assign w_emit   = (w_r >= ROW_MIN) && (w_c >= COL_MIN);

    // lb0 holds the previous row, lb1 the one before; lb1 is refilled from
    // lb0's pre-write value so the two rows age together.
    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb0 (
        .clk     (clk),
        .en      (w_accept),
        .addr    (w_c),
        .wr_data (pixel_in),
        .rd_data (w_mid)
    );

    line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .en      (w_accept),
        .addr    (w_c),
        .wr_data (w_mid),
        .rd_data (w_top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_window     <= '0;
            r_valid_out  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                // Shift every window row one column left.
                for (int k = 0; k < KERNEL_K; k++) begin
                    for (int j = 0; j < KERNEL_K - 1; j++) begin
                        r_window[KERNEL_K*k + j] <= r_window[KERNEL_K*k + j + 1];
                    end
                end
                r_window[KERNEL_K - 1]   <= w_top;
                r_window[2*KERNEL_K - 1] <= w_mid;
                r_window[3*KERNEL_K - 1] <= pixel_in;

                if (w_c == COL_LAST) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= (w_r == ROW_LAST) ? '0 : w_r + RW'(1);
                end else begin
                    r_col_cnt <= w_c + CW'(1);
                    r_row_cnt <= w_r;
                end

                // Columns 0/1 of the first two windows in a row hold stale
                // data from the previous row; the column test drops them.
                if (w_emit) begin
                    r_valid_out  <= 1'b1;
                    r_win_row    <= w_r - ROW_MIN;
                    r_win_col    <= w_c - COL_MIN;
                    r_frame_done <= (w_r == ROW_LAST) && (w_c == COL_LAST);
                end
            end
        end
    end

    assign valid_out  = r_valid_out;
    assign window_out = r_window;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule : conv_window_3x3
`default_nettype wire

// File: tb/tb_conv_window_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_3x3
//  Description : Self-checking bench. A 4x4 instance is driven by directed
//                and random streams and compared cycle by cycle against a
//                frame-image reference model; a 3x3 instance covers the
//                smallest legal frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] pixel_in;
    logic          sof_in;
    logic          valid_out;
    logic [9*DW-1:0] window_out;
    logic [1:0]    win_row;
    logic [1:0]    win_col;
    logic          frame_done;

    logic          v3;
    logic [DW-1:0] p3;
    logic          s3;
    logic          vo3;
    logic [9*DW-1:0] wo3;
    logic [1:0]    wr3;
    logic [1:0]    wc3;
    logic          fd3;

    always #5 clk = ~clk;

    conv_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .pixel_in   (pixel_in),
        .sof_in     (sof_in),
        .valid_out  (valid_out),
        .window_out (window_out),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    conv_window_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .DATA_W(DW)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (v3),
        .pixel_in   (p3),
        .sof_in     (s3),
        .valid_out  (vo3),
        .window_out (wo3),
        .win_row    (wr3),
        .win_col    (wc3),
        .frame_done (fd3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [9*DW-1:0] act,
                         input logic [9*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: the image as written so far plus the raster position.
    logic [DW-1:0]   img [H][W];
    int              m_row = 0;
    int              m_col = 0;
    logic            e_valid;
    logic            e_fd;
    logic [1:0]      e_row;
    logic [1:0]      e_col;
    logic [9*DW-1:0] e_win;
    logic            e_known;

    int              n_valid;
    int              n_fd;
    int              n_gap_valid;
    logic [9*DW-1:0] first_win;
    logic [9*DW-1:0] last_win;
    logic            last_fd;

    task automatic step(input logic v, input logic s, input logic [DW-1:0] p,
                        input logic r, input logic is_gap);
        int rr, cc;
        valid_in = v;
        sof_in   = s;
        pixel_in = p;
        rst      = r;
        if (r) begin
            m_row = 0; m_col = 0;
            e_valid = 0; e_fd = 0; e_row = 0; e_col = 0;
            e_win = '0; e_known = 1;
        end else if (v) begin
            rr = s ? 0 : m_row;
            cc = s ? 0 : m_col;
            img[rr][cc] = p;
            if (rr >= 2 && cc >= 2) begin
                e_valid = 1;
                e_row   = 2'(rr - 2);
                e_col   = 2'(cc - 2);
                e_fd    = (rr == H-1) && (cc == W-1);
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        e_win[DW*(3*a+b) +: DW] = img[rr-2+a][cc-2+b];
                e_known = 1;
            end else begin
                e_valid = 0; e_fd = 0; e_known = 0;
            end
            m_col = cc + 1;
            m_row = rr;
            if (m_col == W) begin
                m_col = 0;
                m_row = (rr + 1 == H) ? 0 : rr + 1;
            end
        end else begin
            e_valid = 0; e_fd = 0;
        end
        @(posedge clk);
        #1;
        check("valid_out", {{(9*DW-1){1'b0}}, valid_out}, {{(9*DW-1){1'b0}}, e_valid});
        check("frame_done", {{(9*DW-1){1'b0}}, frame_done}, {{(9*DW-1){1'b0}}, e_fd});
        if (e_known) check("window_out", window_out, e_win);
        if (e_valid || r) begin
            check("win_row", {{(9*DW-2){1'b0}}, win_row}, {{(9*DW-2){1'b0}}, e_row});
            check("win_col", {{(9*DW-2){1'b0}}, win_col}, {{(9*DW-2){1'b0}}, e_col});
        end
        if (valid_out) begin
            if (n_valid == 0) first_win = window_out;
            last_win = window_out;
            last_fd  = frame_done;
            n_valid++;
            if (is_gap) n_gap_valid++;
        end
        if (frame_done) n_fd++;
    endtask

    task automatic clear_counts();
        n_valid = 0; n_fd = 0; n_gap_valid = 0; last_fd = 0;
        first_win = '0; last_win = '0;
    endtask

    // Feed the first n pixels of the {row,col} pattern frame.
    task automatic feed(input int n, input int gap, input logic sof_first);
        for (int i = 0; i < n; i++) begin
            step(1'b1, sof_first && (i == 0), {8'(i / W), 8'(i % W)}, 1'b0, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b1);
        end
    endtask

    task automatic check_counts(input string tag, input int nv, input int nf);
        check({tag, "_nvalid"}, 144'(n_valid), 144'(nv));
        check({tag, "_nfd"}, 144'(n_fd), 144'(nf));
    endtask

    localparam logic [9*DW-1:0] FIRST_WIN = {16'h0202, 16'h0201, 16'h0200,
                                             16'h0102, 16'h0101, 16'h0100,
                                             16'h0002, 16'h0001, 16'h0000};
    localparam logic [9*DW-1:0] LAST_WIN  = {16'h0303, 16'h0302, 16'h0301,
                                             16'h0203, 16'h0202, 16'h0201,
                                             16'h0103, 16'h0102, 16'h0101};
    localparam logic [9*DW-1:0] WIN3      = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5,
                                             16'd4, 16'd3, 16'd2, 16'd1};

    initial begin
        valid_in = 0; sof_in = 0; pixel_in = '0; rst = 1;
        v3 = 0; p3 = '0; s3 = 0;
        clear_counts();

        // 1: reset then one back-to-back frame
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        clear_counts();
        feed(W*H, 0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_counts("s1", 4, 1);
        check("s1_first_win", first_win, FIRST_WIN);
        check("s1_last_win", last_win, LAST_WIN);
        check("s1_last_fd", {143'd0, last_fd}, 144'd1);

        // 2: 3-cycle gap after every pixel
        clear_counts();
        feed(W*H, 3, 1'b1);
        check_counts("s2", 4, 1);
        check("s2_gap_valid", 144'(n_gap_valid), 144'd0);
        check("s2_first_win", first_win, FIRST_WIN);

        // 3: two frames, sof only on the first
        clear_counts();
        feed(W*H, 0, 1'b1);
        feed(W*H, 0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_counts("s3", 8, 2);

        // 4: sof reasserted at pixel (2,1)
        clear_counts();
        feed(2*W + 1, 0, 1'b1);
        check_counts("s4_pre", 0, 0);
        feed(W*H, 0, 1'b1);
        check_counts("s4", 4, 1);
        check("s4_first_win", first_win, FIRST_WIN);

        // 5: reset during pixel (2,3), then a frame without sof
        feed(2*W + 3, 0, 1'b1);
        step(1'b1, 1'b0, 16'h0203, 1'b1, 1'b0);
        check("s5_rst_win", window_out, '0);
        clear_counts();
        feed(W*H, 0, 1'b0);
        check_counts("s5", 4, 1);
        check("s5_first_win", first_win, FIRST_WIN);

        // Random pixels, gaps, sof and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic v, s, r;
            v = ($urandom_range(9) < 7);
            s = ($urandom_range(19) == 0);
            r = ($urandom_range(99) == 0);
            step(v, s, 16'($urandom), r, 1'b0);
        end

        // 6: smallest frame on the 3x3 instance
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        rst = 0;
        begin
            int   nv3 = 0;
            logic fd_with_valid = 0;
            logic [9*DW-1:0] w3 = '0;
            for (int i = 0; i < 11; i++) begin
                v3 = (i < 9);
                s3 = (i == 0);
                p3 = 16'(i + 1);
                @(posedge clk);
                #1;
                if (vo3) begin
                    nv3++;
                    w3 = wo3;
                    fd_with_valid = fd3;
                end
            end
            v3 = 0;
            check("s6_nvalid", 144'(nv3), 144'd1);
            check("s6_window", w3, WIN3);
            check("s6_fd", {143'd0, fd_with_valid}, 144'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_conv_window_3x3
`default_nettype wire
